// File: rtl/input_capture_pio.sv
`default_nettype none
// ============================================================================
// Module   : input_capture_pio
// Purpose  : Avalon-MM slave that conditions raw board inputs for the soft
//            processor. Each input passes through a 2-flop synchronizer and a
//            counter debouncer. Rising edges of the debounced level are
//            captured into a W1C register, with a per-bit interrupt mask.
// Ports    : clk            - system clock (single domain)
//            reset          - synchronous active-low reset
//            raw_in         - asynchronous raw switch/button levels
//            avs_address    - register word address
//            avs_read       - read strobe (read latency 1)
//            avs_write      - write strobe
//            avs_writedata  - write data
//            avs_readdata   - registered read data, held until next read
//            irq            - level interrupt, any masked capture bit set
//            level_out      - debounced levels for direct hardware use
// Registers: 0 DATA (RO), 1 IRQMASK (RW), 2 EDGECAP (W1C),
//            3 EDGECAP_FALL (W1C when enabled, otherwise reads 0)
// Options  : define INPUT_CAPTURE_FALLING_EDGE_EN to add falling-edge
//            capture at address 3 and fold it into irq.
// Revision : 1.0 - initial release
// ============================================================================
module input_capture_pio #(
  parameter int NUM_INPUTS      = 5,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] raw_in,
  input  logic [1:0]            avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [31:0]           avs_writedata,
  output logic [31:0]           avs_readdata,
  output logic                  irq,
  output logic [NUM_INPUTS-1:0] level_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] c_cnt_last  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]    c_addr_data = 2'd0;
  localparam logic [1:0]    c_addr_mask = 2'd1;
  localparam logic [1:0]    c_addr_edge = 2'd2;
  localparam logic [1:0]    c_addr_fall = 2'd3;

  logic [NUM_INPUTS-1:0] r_sync1;
  logic [NUM_INPUTS-1:0] r_sync2;
  logic [NUM_INPUTS-1:0] r_stable;
  logic [CW-1:0]         r_cnt [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] r_irqmask;
  logic [NUM_INPUTS-1:0] r_edgecap;

  logic [NUM_INPUTS-1:0] w_stable_next;
  logic [CW-1:0]         w_cnt_next [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] w_rise;
  logic [NUM_INPUTS-1:0] w_edge_clr;
  logic [NUM_INPUTS-1:0] w_irq_src;
  logic [31:0]           w_read_mux;
  logic                  w_wr_mask;
  logic                  w_wr_edge;
  logic                  w_unused_ok;

  // Upper write-data bits beyond NUM_INPUTS are intentionally ignored.
  assign w_unused_ok = &{1'b0, avs_writedata};

  assign w_wr_mask  = avs_write && (avs_address == c_addr_mask);
  assign w_wr_edge  = avs_write && (avs_address == c_addr_edge);
  assign w_edge_clr = w_wr_edge ? avs_writedata[NUM_INPUTS-1:0] : '0;

  // Debounce: count consecutive cycles where the synchronized input
  // disagrees with the accepted level; accept after DEBOUNCE_CYCLES.
  always_comb begin
    w_stable_next = r_stable;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_cnt_next[i] = r_cnt[i];
      if (r_sync2[i] == r_stable[i]) begin
        w_cnt_next[i] = '0;
      end else if (r_cnt[i] == c_cnt_last) begin
        w_stable_next[i] = r_sync2[i];
        w_cnt_next[i]    = '0;
      end else begin
        w_cnt_next[i] = r_cnt[i] + CW'(1);
      end
    end
  end

  // Edge detect from the next level so the capture bit sets on the same
  // clock edge that the stable level changes.
  assign w_rise = w_stable_next & ~r_stable;

`ifdef INPUT_CAPTURE_FALLING_EDGE_EN
  logic [NUM_INPUTS-1:0] r_edgecap_fall;
  logic [NUM_INPUTS-1:0] w_fall;
  logic [NUM_INPUTS-1:0] w_fall_clr;
  logic                  w_wr_fall;

  assign w_fall     = ~w_stable_next & r_stable;
  assign w_wr_fall  = avs_write && (avs_address == c_addr_fall);
  assign w_fall_clr = w_wr_fall ? avs_writedata[NUM_INPUTS-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_edgecap_fall <= '0;
    end else begin
      // Set wins over a same-cycle clear.
      r_edgecap_fall <= (r_edgecap_fall & ~w_fall_clr) | w_fall;
    end
  end

  assign w_irq_src = (r_edgecap | r_edgecap_fall) & r_irqmask;
`else
  assign w_irq_src = r_edgecap & r_irqmask;
`endif

  // Read mux samples register state before any same-cycle update.
  always_comb begin
    w_read_mux = 32'd0;
    case (avs_address)
      c_addr_data: w_read_mux = 32'(r_stable);
      c_addr_mask: w_read_mux = 32'(r_irqmask);
      c_addr_edge: w_read_mux = 32'(r_edgecap);
`ifdef INPUT_CAPTURE_FALLING_EDGE_EN
      c_addr_fall: w_read_mux = 32'(r_edgecap_fall);
`else
      c_addr_fall: w_read_mux = 32'd0;
`endif
      default:     w_read_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_stable     <= '0;
      r_irqmask    <= '0;
      r_edgecap    <= '0;
      avs_readdata <= 32'd0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1  <= raw_in;
      r_sync2  <= r_sync1;
      r_stable <= w_stable_next;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
      if (w_wr_mask) begin
        r_irqmask <= avs_writedata[NUM_INPUTS-1:0];
      end
      // Set wins over a same-cycle clear.
      r_edgecap <= (r_edgecap & ~w_edge_clr) | w_rise;
      if (avs_read) begin
        avs_readdata <= w_read_mux;
      end
    end
  end

  assign level_out = r_stable;
  assign irq       = |w_irq_src;

endmodule
`default_nettype wire

// File: tb/tb_input_capture_pio.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_capture_pio
// Purpose  : Self-checking bench for input_capture_pio (NUM_INPUTS=5,
//            DEBOUNCE_CYCLES=8). A reference model accepts a new level once
//            the last DEBOUNCE_CYCLES synchronized samples all disagree with
//            the current level; directed steps plus a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_capture_pio;

  localparam int N = 5;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  raw_in = '0;
  logic [1:0]    avs_address = 2'd0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = 32'd0;
  logic [31:0]   avs_readdata;
  logic          irq;
  logic [N-1:0]  level_out;

  int checks = 0;
  int failures = 0;

  input_capture_pio #(
    .NUM_INPUTS      (N),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .raw_in        (raw_in),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq),
    .level_out     (level_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [N-1:0] m_q1 = '0, m_q2 = '0, m_st = '0;
  logic [N-1:0] m_mask = '0, m_ecap = '0, m_fall = '0;
  logic [31:0]  m_rd = 32'd0;
  logic [N-1:0] hist [$];

  always @(posedge clk) begin : model
    logic [N-1:0] nst, rise, fall, clr2, clr3;
    logic         flip;
    if (!reset) begin
      m_q1 = '0; m_q2 = '0; m_st = '0;
      m_mask = '0; m_ecap = '0; m_fall = '0; m_rd = 32'd0;
      hist.delete();
      for (int j = 0; j < D; j++) hist.push_back('0);
    end else begin
      hist.push_back(m_q2);
      void'(hist.pop_front());
      nst = m_st;
      for (int b = 0; b < N; b++) begin
        flip = 1'b1;
        for (int j = 0; j < D; j++)
          if (hist[j][b] == m_st[b]) flip = 1'b0;
        if (flip) nst[b] = ~m_st[b];
      end
      rise = nst & ~m_st;
      fall = ~nst & m_st;
      if (avs_read) begin
        case (avs_address)
          2'd0: m_rd = 32'(m_st);
          2'd1: m_rd = 32'(m_mask);
          2'd2: m_rd = 32'(m_ecap);
`ifdef INPUT_CAPTURE_FALLING_EDGE_EN
          default: m_rd = 32'(m_fall);
`else
          default: m_rd = 32'd0;
`endif
        endcase
      end
      clr2 = (avs_write && avs_address == 2'd2) ? avs_writedata[N-1:0] : '0;
      clr3 = (avs_write && avs_address == 2'd3) ? avs_writedata[N-1:0] : '0;
      m_ecap = (m_ecap & ~clr2) | rise;
`ifdef INPUT_CAPTURE_FALLING_EDGE_EN
      m_fall = (m_fall & ~clr3) | fall;
`else
      m_fall = '0;
      if (|{clr3, fall}) m_fall = '0;
`endif
      if (avs_write && avs_address == 2'd1) m_mask = avs_writedata[N-1:0];
      m_st = nst;
      m_q2 = m_q1;
      m_q1 = raw_in;
    end
  end

  function automatic logic exp_irq();
`ifdef INPUT_CAPTURE_FALLING_EDGE_EN
    return |((m_ecap | m_fall) & m_mask);
`else
    return |(m_ecap & m_mask);
`endif
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("model_level", 32'(level_out), 32'(m_st));
      chk("model_irq", 32'(irq), 32'(exp_irq()));
      chk("model_rdata", avs_readdata, m_rd);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    step(1);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    avs_address = a; avs_read = 1'b1;
    step(1);
    avs_read = 1'b0;
    chk(tag, avs_readdata, exp);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int hold;
    int r;

    // Reset with inputs all high.
    reset = 1'b0; raw_in = 5'h1F;
    step(3);
    chk("rst_level", 32'(level_out), 32'd0);
    chk("rst_rdata", avs_readdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (i == 9)  chk("pre_accept_level", 32'(level_out), 32'd0);
      if (i == 10) chk("accept_level_10", 32'(level_out), 32'h1F);
    end
    raw_in = '0;
    step(12);
    wr(2'd2, 32'h1F);
    rd(2'd2, 32'h0, "ecap_cleared");

    // Glitch rejection: 7-cycle pulse.
    raw_in[4] = 1'b1; step(7);
    raw_in[4] = 1'b0; step(12);
    chk("glitch_level", 32'(level_out), 32'd0);
    rd(2'd2, 32'h0, "glitch_ecap");

    // 12-cycle pulse is accepted.
    raw_in[4] = 1'b1; step(10);
    chk("pulse_level", 32'(level_out), 32'h10);
    step(2);
    raw_in[4] = 1'b0; step(12);
    rd(2'd2, 32'h10, "pulse_ecap");
    wr(2'd2, 32'h10);

    // Interrupt path.
    wr(2'd1, 32'h10);
    raw_in[4] = 1'b1; step(12);
    chk("irq_set", 32'(irq), 32'd1);
    rd(2'd2, 32'h10, "irq_ecap");
    wr(2'd2, 32'h10);
    chk("irq_cleared", 32'(irq), 32'd0);
    rd(2'd2, 32'h0, "ecap_w1c");

    // Set-wins: W1C of bit 0 on the edge stable[0] rises.
    wr(2'd1, 32'h01);
    raw_in[0] = 1'b1; step(9);
    wr(2'd2, 32'h01);
    chk("setwins_irq", 32'(irq), 32'd1);
    rd(2'd2, 32'h01, "setwins_ecap");
    wr(2'd2, 32'h01);

    // Bus rules.
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, 32'h11, "data_readonly");
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'h1F, "mask_readback");
    wr(2'd3, 32'h1F);
    rd(2'd3, 32'h0, "addr3_zero");

    // Falling-edge capture (or its absence).
    wr(2'd1, 32'h04);
    raw_in[2] = 1'b1; step(12);
    wr(2'd2, 32'h04);
    raw_in[2] = 1'b0; step(12);
`ifdef INPUT_CAPTURE_FALLING_EDGE_EN
    rd(2'd3, 32'h04, "fall_capture");
    chk("fall_irq", 32'(irq), 32'd1);
    wr(2'd3, 32'h04);
    rd(2'd3, 32'h0, "fall_w1c");
    chk("fall_irq_clr", 32'(irq), 32'd0);
`else
    rd(2'd3, 32'h0, "fall_disabled");
    chk("fall_irq_off", 32'(irq), 32'd0);
`endif

    // Reset mid-read and mid-debounce.
    raw_in = 5'h0A; step(5);
    avs_address = 2'd1; avs_read = 1'b1; reset = 1'b0;
    step(1);
    avs_read = 1'b0;
    chk("rst_midread", avs_readdata, 32'd0);
    chk("rst_mid_level", 32'(level_out), 32'd0);
    reset = 1'b1;

    // Randomized phase.
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        raw_in = N'($urandom);
        hold = int'($urandom_range(1, 14));
      end
      r = int'($urandom_range(0, 7));
      avs_read      = (r < 3);
      avs_write     = (r == 3) || (r == 4);
      avs_address   = 2'($urandom);
      avs_writedata = $urandom;
      step(1);
      hold--;
    end
    avs_read = 1'b0; avs_write = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/input_capture_pio.md
Name: input_capture_pio

Overview:
- Avalon-MM slave that conditions the stopwatch's raw board inputs (mode switches, pause switch, reset switch, start button) and presents them to the soft processor.
- It is the processor-facing read side that complements the output PIOs driving the displays and LEDs.
- Per input: 2-flop synchronizer, then counter debouncer, then rising-edge capture with per-bit interrupt mask.
- Software reads levels and pending events over the bus; irq flags a masked event.

Parameters:
- NUM_INPUTS, 5, number of conditioned inputs (1..32).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level (10 ms at 50 MHz); must be >= 1.

Ports:
- clk  input  1  system clock; the single clock domain.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- raw_in  input  NUM_INPUTS  asynchronous raw switch/button levels.
- avs_address  input  2  register word address.
- avs_read  input  1  read strobe.
- avs_write  input  1  write strobe.
- avs_writedata  input  32  write data.
- avs_readdata  output  32  read data, fixed read latency 1.
- irq  output  1  level interrupt; 1 while any masked edge-capture bit is set.
- level_out  output  NUM_INPUTS  debounced levels, for direct hardware use.

Behaviour:
- Reset (reset==0 at a clk edge): all of the following clear to 0:
  - synchronizer flops, stable levels, debounce counters;
  - IRQMASK, EDGECAP, EDGECAP_FALL;
  - avs_readdata, irq, level_out.
- Reset mid-debounce discards partial counts. Reset mid-read drives avs_readdata to 0 on the next cycle.
- Synchronizer: sync = raw_in delayed by 2 flops.
- Debounce, per bit:
  - Counter width clog2(DEBOUNCE_CYCLES+1).
  - If sync==stable: counter <= 0.
  - Else if counter==DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
  - Else: counter <= counter+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles leaves stable unchanged.
  - stable updates exactly 2+DEBOUNCE_CYCLES cycles after a raw step that holds.
- level_out = stable (registered, no extra latency).
- Edge detect: rise = stable_next & ~stable. The EDGECAP bit sets on the same edge that stable goes 1.
- Register map (word addresses):
  - 0 DATA: read-only, bits[NUM_INPUTS-1:0] = stable, upper bits 0; writes ignored.
  - 1 IRQMASK: read/write, bits[NUM_INPUTS-1:0]; upper write bits ignored, upper read bits 0.
  - 2 EDGECAP: read / write-1-to-clear; writing 0 bits has no effect.
  - 3 EDGECAP_FALL: see Optional Feature; otherwise reads 0 and writes are ignored.
- Read: avs_read at cycle N → avs_readdata valid at cycle N+1 and held until the next read.
  - No waitrequest.
  - Read data reflects register state at edge N, before any same-cycle update.
- Simultaneous read and write in one cycle: the write takes effect; readdata returns pre-write contents.
- Simultaneous W1C and new edge on the same bit: set wins, bit stays 1.
- irq = |(EDGECAP & IRQMASK), driven from registers.
  - irq rises in the same cycle the capture bit is visible.
  - irq falls the cycle after a clearing write or mask write.

Optional Feature:
- Macro: INPUT_CAPTURE_FALLING_EDGE_EN.
- Defined:
  - Address 3 EDGECAP_FALL captures falling edges (stable 1→0) with the same W1C and set-wins rules.
  - irq = |((EDGECAP | EDGECAP_FALL) & IRQMASK).
- Undefined:
  - No falling-edge logic is instantiated.
  - Address 3 reads 0 and writes are ignored.
  - irq uses EDGECAP only.

Test Plan (bench uses NUM_INPUTS=5, DEBOUNCE_CYCLES=8):
- Reset: hold reset=0 for 3 cycles with raw_in=5'b11111, then release → level_out=0, avs_readdata=0, irq=0 until the debounce completes; level_out=5'b11111 exactly 10 cycles after release.
- Glitch rejection: raw_in[4] pulses high for 7 cycles → level_out[4] stays 0 and EDGECAP stays 0. A 12-cycle pulse → level_out[4]=1 for the remainder of the pulse after the 10-cycle delay, and EDGECAP[4]=1.
- Interrupt path:
  - Write IRQMASK=0x10, press raw_in[4] → irq=1.
  - Read addr 2 → 0x00000010 one cycle after avs_read.
  - Write addr 2 data 0x10 → EDGECAP=0 and irq=0 next cycle.
- Set-wins collision: a W1C of bit 0 lands in the cycle stable[0] rises → EDGECAP[0]=1 and irq stays 1 (mask 0x01).
- Bus rules:
  - Write addr 0 data 0xFFFFFFFF → DATA unchanged.
  - Write IRQMASK 0xFFFFFFFF → reads back 0x0000001F.
  - Addr 3 reads 0 with the macro undefined.
- With INPUT_CAPTURE_FALLING_EDGE_EN: release raw_in[2] after a press → addr 3 reads 0x04 and irq=1 with mask 0x04; W1C 0x04 → 0.
